btn_mode_ring: RTL and testbench

- Push-button mode selector: debounces and synchronizes a raw button, detects clean press/release edges, and on each debounced press advances a one-hot N-state ring counter.
- Sits between the board button pin and the output-mode mux of the bike-light datapath.
- The mode mux consumes state[0..N-1], e.g. OFF/ON/BLINK/DIM.

---
 rtl/btn_mode_ring.sv | 89 ++++++++
 tb/tb_btn_mode_ring.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/btn_mode_ring.sv
// btn_mode_ring: two-flop synchronizer, debouncer with edge pulses, and a one-hot mode ring.
// Optional macro MODE_ERR_FLAG_EN adds a state_err pulse after illegal-state recovery.
module btn_mode_ring #(
  parameter int T = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn,
  output logic         conditioned,
  output logic         rising,
  output logic         falling,
  output logic [N-1:0] state
`ifdef MODE_ERR_FLAG_EN
  ,
  output logic         state_err
`endif
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] LAST = CW'(T - 1);
  localparam logic [N-1:0] MODE0 = {{(N-1){1'b0}}, 1'b1};

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] count;
  logic          one_hot;
  logic [N-1:0]  next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
    end
  end

  // A level change is accepted only after T consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      conditioned <= 1'b0;
      rising      <= 1'b0;
      falling     <= 1'b0;
    end else if (sync1 == conditioned) begin
      count   <= '0;
      rising  <= 1'b0;
      falling <= 1'b0;
    end else if (count != LAST) begin
      count   <= count + 1'b1;
      rising  <= 1'b0;
      falling <= 1'b0;
    end else begin
      conditioned <= sync1;
      count       <= '0;
      rising      <= sync1;
      falling     <= ~sync1;
    end
  end

  // Recovery from a corrupted ring takes priority over advancing.
  always_comb begin
    one_hot    = (state != '0) && ((state & (state - 1'b1)) == '0);
    next_state = state;
    if (!one_hot)
      next_state = MODE0;
    else if (rising)
      next_state = {state[N-2:0], state[N-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= MODE0;
    else
      state <= next_state;
  end

`ifdef MODE_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_err <= 1'b0;
    else
      state_err <= ~one_hot;
  end
`endif

endmodule

// File: tb/tb_btn_mode_ring.sv
// Scoreboard bench for btn_mode_ring: stimulus pushes expected pulses, a monitor pops and checks them.
// Define MODE_ERR_FLAG_EN to also check the state_err pulse.
module tb_btn_mode_ring;
  localparam int T = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         btn;
  logic         conditioned;
  logic         rising;
  logic         falling;
  logic [N-1:0] state;
`ifdef MODE_ERR_FLAG_EN
  logic         state_err;
`endif

  btn_mode_ring #(.T(T), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .conditioned (conditioned),
    .rising      (rising),
    .falling     (falling),
    .state       (state)
`ifdef MODE_ERR_FLAG_EN
    ,
    .state_err   (state_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_rise;
    int           at_cyc;
    logic [N-1:0] st;
  } exp_t;

  exp_t         q[$];
  exp_t         item;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [N-1:0] exp_state;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] rot(input logic [N-1:0] s);
    return {s[N-2:0], s[N-1]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every observed pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rising !== 1'b0 || falling !== 1'b0)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_pulse: rising=%b falling=%b state=%b at cycle %0d expected none",
                 rising, falling, state, cyc);
      end else begin
        item = q.pop_front();
        if (rising !== item.is_rise || falling !== !item.is_rise || cyc != item.at_cyc ||
            conditioned !== item.is_rise || state !== item.st) begin
          n_err++;
          $display("[TB] FAIL pulse: got rise=%b fall=%b cond=%b state=%b cyc=%0d expected rise=%b cond=%b state=%b cyc=%0d",
                   rising, falling, conditioned, state, cyc,
                   item.is_rise, item.is_rise, item.st, item.at_cyc);
        end
      end
    end
  end

  // Press for hold cycles, release, then idle gap cycles; called at a negedge.
  task automatic apply_stimulus(input int hold, input int gap);
    int e;
    e   = cyc;
    btn = 1'b1;
    if (hold >= T) begin
      q.push_back('{1'b1, e + T + 2, exp_state});
      exp_state = rot(exp_state);
      q.push_back('{1'b0, e + hold + T + 2, exp_state});
    end
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int e;
    int r;
    rst_n     = 1'b0;
    btn       = 1'b0;
    exp_state = 4'b0001;

    // Reset with a toggling button
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn = ~btn;
    end
    @(negedge clk);
    check_output("reset_state", 32'(state), 32'(4'b0001));
    check_output("reset_conditioned", 32'(conditioned), 32'd0);
    check_output("reset_rising", 32'(rising), 32'd0);
    check_output("reset_falling", 32'(falling), 32'd0);
    btn   = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("idle_state", 32'(state), 32'(4'b0001));
    check_output("idle_conditioned", 32'(conditioned), 32'd0);

    // Clean press
    apply_stimulus(10, 12);
    check_output("clean_press_state", 32'(state), 32'(4'b0010));

    // Glitch of T-1 cycles is rejected, exactly T is accepted
    apply_stimulus(T - 1, 12);
    check_output("glitch3_state", 32'(state), 32'(exp_state));
    apply_stimulus(T, 12);
    check_output("glitch4_state", 32'(state), 32'(4'b0100));

    // Bounce: 2-cycle toggles, then a stable press
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    apply_stimulus(12, 12);
    check_output("bounce_state", 32'(state), 32'(4'b1000));

    // Wrap-around across four presses
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8, 12);
      check_output($sformatf("wrap_state_%0d", i), 32'(state), 32'(exp_state));
    end

    // Illegal state injected while rising is high
    e   = cyc;
    btn = 1'b1;
    q.push_back('{1'b1, e + T + 2, exp_state});
    repeat (T + 2) @(negedge clk);
    #2 force dut.state = 4'b0110;
    #1 release dut.state;
    @(negedge clk);
    check_output("illegal_fix_state", 32'(state), 32'(4'b0001));
`ifdef MODE_ERR_FLAG_EN
    check_output("state_err_high", 32'(state_err), 32'd1);
`endif
    exp_state = 4'b0001;
    @(negedge clk);
    check_output("illegal_hold_state", 32'(state), 32'(4'b0001));
`ifdef MODE_ERR_FLAG_EN
    check_output("state_err_low", 32'(state_err), 32'd0);
`endif
    r   = cyc;
    btn = 1'b0;
    q.push_back('{1'b0, r + T + 2, exp_state});
    repeat (12) @(negedge clk);

    // All-zero state with the button idle
    #2 force dut.state = 4'b0000;
    #1 release dut.state;
    @(negedge clk);
    check_output("zero_fix_state", 32'(state), 32'(4'b0001));
    repeat (3) @(negedge clk);

    while (q.size() > 0) begin
      item = q.pop_front();
      n_cmp++;
      n_err++;
      $display("[TB] FAIL missing_pulse: got none expected rise=%b at cycle %0d", item.is_rise, item.at_cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
